// File: rtl/hamming_enc_seq.sv
// hamming_enc_seq
// Sequencer that walks a block of data memory through the external
// combinational Hamming (16,11) SECDED encoder. For each message k it reads
// two source bytes and presents them to the encoder as regA/regB. It then
// writes the encoder's LSW and MSW back to the destination region.
//
// State table (state | meaning):
//   IDLE   | after reset, waiting for Start
//   RD_LO  | read low message byte (b8..b1)
//   RD_HI  | latch low byte into regB, read high message byte
//   CAP_HI | latch b11..b9 into regA, encoder settles
//   WR_LO  | write encoder LSW to DST_BASE+2k
//   WR_HI  | write encoder MSW to DST_BASE+2k+1, advance k or finish
//   DONE   | run complete, waiting for Start to rerun
//
// Ports:
//   CLK, Reset         clock (rising edge), async active-low reset
//   Start              single-cycle start pulse, honoured in IDLE/DONE only
//   Busy, Done         run in progress / run complete
//   MsgIdx             index of the message being processed
//   MemAddr, MemRdEn   memory address, read request (data next cycle)
//   MemRdData          synchronous read data
//   MemWrEn, MemWrData write strobe and data
//   EncRegA, EncRegB   registered encoder inputs
//   EncMSW, EncLSW     combinational encoder outputs
module hamming_enc_seq #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Start,
  output logic          Busy,
  output logic          Done,
  output logic [3:0]    MsgIdx,
  output logic [AW-1:0] MemAddr,
  output logic          MemRdEn,
  input  logic [7:0]    MemRdData,
  output logic          MemWrEn,
  output logic [7:0]    MemWrData,
  output logic [7:0]    EncRegA,
  output logic [7:0]    EncRegB,
  input  logic [7:0]    EncMSW,
  input  logic [7:0]    EncLSW
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_LO  = 3'd1;
  localparam logic [2:0] RD_HI  = 3'd2;
  localparam logic [2:0] CAP_HI = 3'd3;
  localparam logic [2:0] WR_LO  = 3'd4;
  localparam logic [2:0] WR_HI  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam logic [3:0]    K_LAST = 4'(NUM_MSG - 1);
  localparam logic [AW-1:0] SRC_A  = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A  = AW'(DST_BASE);

  logic [2:0]    state;
  logic [3:0]    k;
  logic [7:0]    enc_a;
  logic [7:0]    enc_b;
  logic [AW-1:0] offset;

  // Byte offset 2k of the current message; wraps modulo 2^AW.
  assign offset = AW'({k, 1'b0});

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      k     <= '0;
      enc_a <= '0;
      enc_b <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state <= RD_LO;
            k     <= '0;
          end
        end
        RD_LO: state <= RD_HI;
        RD_HI: begin
          enc_b <= MemRdData;
          state <= CAP_HI;
        end
        CAP_HI: begin
          // Only b11..b9 are message bits; the rest of the high byte is ignored.
          enc_a <= {5'b0, MemRdData[2:0]};
          state <= WR_LO;
        end
        WR_LO: state <= WR_HI;
        WR_HI: begin
          if (k == K_LAST) begin
            state <= DONE;
          end else begin
            k     <= k + 4'd1;
            state <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    MemAddr   = '0;
    MemRdEn   = 1'b0;
    MemWrEn   = 1'b0;
    MemWrData = '0;
    case (state)
      RD_LO: begin
        MemAddr = SRC_A + offset;
        MemRdEn = 1'b1;
      end
      RD_HI: begin
        MemAddr = SRC_A + offset + AW'(1);
        MemRdEn = 1'b1;
      end
      WR_LO: begin
        MemAddr   = DST_A + offset;
        MemWrEn   = 1'b1;
        MemWrData = EncLSW;
      end
      WR_HI: begin
        MemAddr   = DST_A + offset + AW'(1);
        MemWrEn   = 1'b1;
        MemWrData = EncMSW;
      end
      default: ;
    endcase
  end

  assign Busy    = (state != IDLE) && (state != DONE);
  assign Done    = (state == DONE);
  assign MsgIdx  = k;
  assign EncRegA = enc_a;
  assign EncRegB = enc_b;

endmodule

// File: doc/hamming_enc_seq.md
Name: hamming_enc_seq

Overview:
- Sequencer that drives the Hamming (16,11) SECDED encoder datapath across a block of data memory.
- Reads each 11-bit message as two bytes from a source region and presents them to the encoder as regA/regB.
- Captures the encoder's MSW/LSW and writes them to a destination region.
- Sits between data memory and the combinational encoder, and replaces the software loop for program 1.

Parameters:
- NUM_MSG, 15, number of messages to encode per run.
- SRC_BASE, 0, byte address of the first message byte.
- DST_BASE, 30, byte address of the first output byte.
- AW, 8, memory address width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle start pulse; sampled only in IDLE or DONE.
- Busy  out  1  high while a run is in progress.
- Done  out  1  high from run completion until the next Start or Reset.
- MsgIdx  out  4  index k of the message currently being processed.
- MemAddr  out  AW  memory address for the read or write this cycle.
- MemRdEn  out  1  read request; data returns on MemRdData the following cycle.
- MemRdData  in  8  synchronous read data, one-cycle latency.
- MemWrEn  out  1  write strobe; MemAddr/MemWrData written at the next edge.
- MemWrData  out  8  write data.
- EncRegA  out  8  to encoder regA: {5'b0, b11..b9}.
- EncRegB  out  8  to encoder regB: b8..b1.
- EncMSW  in  8  encoder MSW (combinational from EncRegA/EncRegB).
- EncLSW  in  8  encoder LSW.

Behaviour:
- Reset (Reset low, asynchronous):
  - state=IDLE, k=0.
  - Busy, Done, MemRdEn, MemWrEn = 0; MemAddr, MemWrData, EncRegA, EncRegB = 0.
  - Reset mid-run aborts the run. Bytes already written stay in memory; there is no resume.
- Memory layout:
  - Message k: low byte at SRC_BASE+2k (b8..b1), high byte at SRC_BASE+2k+1 (b11..b9 in bits [2:0]).
  - Output: LSW at DST_BASE+2k, MSW at DST_BASE+2k+1.
- FSM, 7 states:
  - IDLE: Start=1 -> RD_LO, k=0, Busy=1.
  - RD_LO: MemAddr=SRC_BASE+2k, MemRdEn=1 -> RD_HI.
  - RD_HI: EncRegB<=MemRdData; MemAddr=SRC_BASE+2k+1, MemRdEn=1 -> CAP_HI.
  - CAP_HI: EncRegA<={5'b0, MemRdData[2:0]}. Upper 5 bits are forced to 0 regardless of memory contents. -> WR_LO.
  - WR_LO: MemAddr=DST_BASE+2k, MemWrData=EncLSW, MemWrEn=1 -> WR_HI.
  - WR_HI: MemAddr=DST_BASE+2k+1, MemWrData=EncMSW, MemWrEn=1.
    - If k==NUM_MSG-1 -> DONE.
    - Else k<=k+1 -> RD_LO.
  - DONE: Busy=0, Done=1. Start=1 -> RD_LO, k=0, Done=0, Busy=1.
- Output decoding and hold rules:
  - MemRdEn and MemWrEn are decoded from the current state and are never both high.
  - MemAddr is 0 in IDLE and DONE.
  - EncRegA/EncRegB are registered and hold stable through WR_LO and WR_HI.
- Latency:
  - 5 cycles per message.
  - Start sampled at edge E0 -> Done rises at edge E0 + 5·NUM_MSG (E75 at default).
- Start handling:
  - Ignored in any state other than IDLE or DONE; no queuing.
  - A Start held high for multiple cycles in DONE restarts once per sampling, so Start is required to be a single-cycle pulse.
- Address arithmetic:
  - Modulo 2^AW; no range check.
  - The default configuration never wraps (max address 59).
- MsgIdx equals k; it holds NUM_MSG-1 in DONE and 0 in IDLE.

Test Plan:
- Reset then idle: Reset low mid-cycle -> all outputs 0 immediately. Reset high and no Start for 20 cycles -> no MemRdEn/MemWrEn activity, Busy=0.
- All-zero messages (mem[0:29]=0x00), Start pulse -> mem[30:59]=0x00. Done rises exactly 75 cycles after Start is sampled; Busy is high for those 75 cycles.
- Message 0 = 11'h7FF (mem[0]=0xFF, mem[1]=0x07) -> mem[30]=0xFF, mem[31]=0xFF. With mem[1]=0xFF instead, the result is unchanged (upper-bit masking).
- Message 1 = 11'h001 (mem[2]=0x01, mem[3]=0x00) -> mem[32]=0x0F, mem[33]=0x00. Every write cycle shows the correct address ordering: LSW then MSW.
- Start pulses during Busy are ignored: final memory and Done timing match the no-pulse run. Start in DONE restarts: Done drops next cycle and the run repeats with identical results.
- Reset asserted in CAP_HI of message 5 -> mem[30:39] written, mem[40:59] untouched. After Reset release and a Start, the full run completes correctly.
